outbuf_cell: RTL and testbench
==============================

Name: outbuf_cell

Overview:
- Output-side buffer for one router output port; feeds the neighbour router's input buffer over the so/ro/do link.
- Holds one 64-bit packet per virtual channel (VC0 = even, VC1 = odd).
- Written by the internal switch during a VC's internal phase; drained onto the link during that VC's external phase.
- The polarity bit alternates the two VCs between phases every cycle.

Parameters:
- DW, 64, packet width in bits
- VC_BIT, 63, index of the packet bit that selects the VC (0 = VC0, 1 = VC1)
- CW, 16, width of the transmitted-packet counter

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately on assertion
- polarity  input  1  0: VC0 internal / VC1 external; 1: VC1 internal / VC0 external
- wr_en  input  1  switch presents a packet this cycle
- wr_data  input  DW  packet from switch; VC taken from wr_data[VC_BIT]
- wr_ready  output  2  per-VC readiness to switch: bit v = internal phase for v & ~full[v]
- so  output  1  send valid to downstream neighbour
- ro  input  1  downstream neighbour ready
- do  output  DW  packet to downstream neighbour
- full  output  2  per-VC occupancy flag
- wr_err  output  1  sticky: write attempted to a VC not ready
- tx_count  output  CW  total packets handed to the link, wraps modulo 2^CW

Behaviour:
- Reset, asynchronous: full=2'b00, both data registers = 0, wr_err=0, tx_count=0. so, do and wr_ready fall to 0 combinationally.
- Phase decode:
  - int_vc = polarity; ext_vc = ~polarity.
  - A given VC is never in both phases in the same cycle.
- Write (internal phase):
  - Let v = wr_data[VC_BIT].
  - Accept when wr_en & (v == int_vc) & ~full[v]. At the next edge: buf[v] <= wr_data, full[v] <= 1.
  - wr_en with v == ext_vc, or with full[v] already set: the packet is dropped, buffer and full are unchanged, and wr_err <= 1.
  - wr_err stays set until reset.
  - wr_ready is combinational from full and polarity, so the switch can arbitrate in the same cycle.
- Send (external phase):
  - so = full[ext_vc]; do = buf[ext_vc] when so=1, else 0.
  - Transfer occurs at the edge where so & ro = 1: full[ext_vc] <= 0 and tx_count <= tx_count + 1 (wraps 0xFFFF -> 0x0000). Data register is unchanged.
  - so=1 & ro=0: packet is held, so stays asserted for as long as polarity keeps that VC external. When polarity flips, so drops; the packet is retried on the VC's next external phase. No loss, no duplication.
- Latency: a packet written at edge N can appear on so/do no earlier than the cycle after edge N, provided polarity has flipped to make its VC external. With polarity toggling every cycle, the minimum is 1 cycle.
- Simultaneous events:
  - A write to int_vc and a send from ext_vc in the same cycle are independent and both complete.
  - The same VC can never be written and drained in one cycle.
- Buffer full: a full VC blocks further writes to that VC (wr_ready=0) until drained.
- Both VCs full: each drains on its own external phase.
- Reset mid-transfer: any packet in flight is discarded, and so deasserts without waiting for a clock edge.
- No combinational path from ro to so or to wr_ready. ro affects state only.

Test Plan:
- Reset, then polarity=0, wr_en=1, wr_data=64'h0000_0000_0000_00A5 -> full=01 after edge. Next cycle polarity=1, ro=1 -> so=1, do=64'h...A5; after edge full=00, tx_count=1.
- Write VC1 packet 64'h8000_0000_0000_0011 at polarity=1, then hold ro=0 for 4 cycles while polarity toggles -> so pulses high only when polarity=0. Packet is retained with full[1]=1. Raise ro at polarity=0 -> single transfer, tx_count increments by exactly 1.
- Write to VC0 while polarity=1 (VC0 external) -> packet dropped, full unchanged, wr_err=1 and stays 1 through later good traffic.
- Fill both VCs, toggle polarity with ro=1 for 2 cycles -> VC1 then VC0 (or the reverse, per polarity) each sent once. Meanwhile a concurrent write into the freshly drained internal VC succeeds in the same cycle as the other VC's send.
- Preload tx_count to 0xFFFF via 65535 sends (or force), one more send -> tx_count=0x0000.
- Assert reset asynchronously mid-cycle while so=1 -> so, do, full, wr_err and tx_count go to 0 before the next clk edge. After release, normal write/send resumes.

Source files
------------

// File: rtl/outbuf_cell_if.sv
// Link-side bundle for one router output buffer: switch write port, downstream
// so/ro/data link, and status.
interface outbuf_cell_if #(
    parameter int DW = 64,
    parameter int CW = 16
);
    // Handshakes: a switch write is accepted at the edge where wr_en is high and
    // wr_ready[vc] is high for the packet's VC. A link transfer completes at the
    // edge where so & ro; so never depends on ro.
    logic          polarity;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [1:0]    wr_ready;
    logic          so;
    logic          ro;
    logic [DW-1:0] do_data;
    logic [1:0]    full;
    logic          wr_err;
    logic [CW-1:0] tx_count;

    modport master (
        output polarity, wr_en, wr_data, ro,
        input  wr_ready, so, do_data, full, wr_err, tx_count
    );

    modport slave (
        input  polarity, wr_en, wr_data, ro,
        output wr_ready, so, do_data, full, wr_err, tx_count
    );
endinterface

// File: rtl/outbuf_cell.sv
// Two-VC output buffer: one packet slot per VC, written during the VC's internal
// phase and drained onto the link during its external phase.
module outbuf_cell #(
    parameter int DW     = 64,
    parameter int VC_BIT = 63,
    parameter int CW     = 16
) (
    input logic          clk,
    input logic          reset,
    outbuf_cell_if.slave bus
);
    logic [1:0][DW-1:0] buf_q, buf_d;
    logic [1:0]         full_q, full_d;
    logic               wr_err_q, wr_err_d;
    logic [CW-1:0]      tx_count_q, tx_count_d;

    logic       int_vc;
    logic       ext_vc;
    logic       wr_vc;
    logic       wr_ok;
    logic       send;
    logic [1:0] wr_ready;

    always_comb begin
        int_vc     = bus.polarity;
        ext_vc     = ~bus.polarity;
        wr_vc      = bus.wr_data[VC_BIT];
        wr_ready   = 2'b00;
        buf_d      = buf_q;
        full_d     = full_q;
        wr_err_d   = wr_err_q;
        tx_count_d = tx_count_q;

        // Only the internal VC can be ready; reset forces the switch off at once.
        if (!reset) begin
            wr_ready[int_vc] = ~full_q[int_vc];
        end
        wr_ok = bus.wr_en & wr_ready[wr_vc];
        send  = full_q[ext_vc] & bus.ro;

        if (wr_ok) begin
            buf_d[wr_vc]  = bus.wr_data;
            full_d[wr_vc] = 1'b1;
        end else if (bus.wr_en) begin
            wr_err_d = 1'b1;
        end

        // wr_vc and ext_vc always differ when both fire, so these never collide.
        if (send) begin
            full_d[ext_vc] = 1'b0;
            tx_count_d     = tx_count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_q      <= '0;
            full_q     <= 2'b00;
            wr_err_q   <= 1'b0;
            tx_count_q <= '0;
        end else begin
            buf_q      <= buf_d;
            full_q     <= full_d;
            wr_err_q   <= wr_err_d;
            tx_count_q <= tx_count_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.so       = full_q[ext_vc];
    assign bus.do_data  = full_q[ext_vc] ? buf_q[ext_vc] : '0;
    assign bus.full     = full_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.tx_count = tx_count_q;
endmodule

// File: tb/tb_outbuf_cell.sv
// Directed bench for outbuf_cell: reset, write/send, hold under ro=0, error
// stickiness, both-VC traffic, counter wrap and asynchronous reset.
module tb_outbuf_cell;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [15:0] exp_tx;

    outbuf_cell_if #(.DW(64), .CW(16)) bus ();

    outbuf_cell #(.DW(64), .VC_BIT(63), .CW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic p, input logic we, input logic [63:0] d, input logic r);
        bus.polarity = p;
        bus.wr_en    = we;
        bus.wr_data  = d;
        bus.ro       = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.full !== 2'b00) begin $display("FAIL rst_full got=%h exp=00", bus.full); bad++; end
        total++; if (bus.so !== 1'b0) begin $display("FAIL rst_so got=%b exp=0", bus.so); bad++; end
        total++; if (bus.do_data !== 64'h0) begin $display("FAIL rst_do got=%h exp=0", bus.do_data); bad++; end
        total++; if (bus.wr_ready !== 2'b00) begin $display("FAIL rst_wr_ready got=%b exp=00", bus.wr_ready); bad++; end
        total++; if (bus.wr_err !== 1'b0) begin $display("FAIL rst_wr_err got=%b exp=0", bus.wr_err); bad++; end
        total++; if (bus.tx_count !== 16'h0) begin $display("FAIL rst_tx got=%h exp=0", bus.tx_count); bad++; end
        tick();
        reset = 1'b0;
        #1;
        total++; if (bus.wr_ready !== 2'b01) begin $display("FAIL rel_wr_ready got=%b exp=01", bus.wr_ready); bad++; end
    endtask

    task automatic test_basic();
        drive(1'b0, 1'b1, 64'h0000_0000_0000_00A5, 1'b0);
        total++; if (bus.wr_ready !== 2'b01) begin $display("FAIL basic_wr_ready got=%b exp=01", bus.wr_ready); bad++; end
        tick();
        total++; if (bus.full !== 2'b01) begin $display("FAIL basic_full got=%b exp=01", bus.full); bad++; end
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        total++; if (bus.so !== 1'b1) begin $display("FAIL basic_so got=%b exp=1", bus.so); bad++; end
        total++; if (bus.do_data !== 64'h0000_0000_0000_00A5) begin $display("FAIL basic_do got=%h exp=a5", bus.do_data); bad++; end
        total++; if (bus.wr_ready !== 2'b10) begin $display("FAIL basic_wr_ready1 got=%b exp=10", bus.wr_ready); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.full !== 2'b00) begin $display("FAIL basic_drain got=%b exp=00", bus.full); bad++; end
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL basic_tx got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
    endtask

    task automatic test_hold();
        logic        p;
        logic        exp_so;
        logic [63:0] exp_do;
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0011, 1'b0);
        total++; if (bus.wr_ready !== 2'b10) begin $display("FAIL hold_wr_ready got=%b exp=10", bus.wr_ready); bad++; end
        tick();
        total++; if (bus.full !== 2'b10) begin $display("FAIL hold_full got=%b exp=10", bus.full); bad++; end
        for (int i = 0; i < 4; i++) begin
            p      = i[0];
            exp_so = ~p;
            exp_do = p ? 64'h0 : 64'h8000_0000_0000_0011;
            drive(p, 1'b0, 64'h0, 1'b0);
            total++; if (bus.so !== exp_so) begin $display("FAIL hold_so[%0d] got=%b exp=%b", i, bus.so, exp_so); bad++; end
            total++; if (bus.do_data !== exp_do) begin $display("FAIL hold_do[%0d] got=%h exp=%h", i, bus.do_data, exp_do); bad++; end
            tick();
            total++; if (bus.full !== 2'b10) begin $display("FAIL hold_keep[%0d] got=%b exp=10", i, bus.full); bad++; end
            total++; if (bus.tx_count !== exp_tx) begin $display("FAIL hold_tx[%0d] got=%h exp=%h", i, bus.tx_count, exp_tx); bad++; end
        end
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        total++; if (bus.so !== 1'b1) begin $display("FAIL hold_retry_so got=%b exp=1", bus.so); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.full !== 2'b00) begin $display("FAIL hold_drain got=%b exp=00", bus.full); bad++; end
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL hold_tx_send got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        total++; if (bus.so !== 1'b0) begin $display("FAIL hold_empty_so got=%b exp=0", bus.so); bad++; end
        tick();
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL hold_no_dup got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
    endtask

    task automatic test_wr_err();
        total++; if (bus.wr_err !== 1'b0) begin $display("FAIL err_clean got=%b exp=0", bus.wr_err); bad++; end
        drive(1'b1, 1'b1, 64'h0000_0000_0000_0022, 1'b0);
        tick();
        total++; if (bus.full !== 2'b00) begin $display("FAIL err_full got=%b exp=00", bus.full); bad++; end
        total++; if (bus.wr_err !== 1'b1) begin $display("FAIL err_set got=%b exp=1", bus.wr_err); bad++; end
        drive(1'b0, 1'b1, 64'h0000_0000_0000_0033, 1'b0);
        tick();
        total++; if (bus.full !== 2'b01) begin $display("FAIL err_good_full got=%b exp=01", bus.full); bad++; end
        total++; if (bus.wr_err !== 1'b1) begin $display("FAIL err_sticky1 got=%b exp=1", bus.wr_err); bad++; end
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        total++; if (bus.do_data !== 64'h33) begin $display("FAIL err_do got=%h exp=33", bus.do_data); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL err_tx got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
        total++; if (bus.wr_err !== 1'b1) begin $display("FAIL err_sticky2 got=%b exp=1", bus.wr_err); bad++; end
    endtask

    task automatic test_both_full();
        drive(1'b0, 1'b1, 64'h44, 1'b0);
        tick();
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0055, 1'b0);
        total++; if (bus.do_data !== 64'h44) begin $display("FAIL both_hold_do got=%h exp=44", bus.do_data); bad++; end
        tick();
        total++; if (bus.full !== 2'b11) begin $display("FAIL both_full got=%b exp=11", bus.full); bad++; end
        drive(1'b0, 1'b1, 64'h66, 1'b1);
        total++; if (bus.wr_ready !== 2'b00) begin $display("FAIL both_wr_ready got=%b exp=00", bus.wr_ready); bad++; end
        total++; if (bus.do_data !== 64'h8000_0000_0000_0055) begin $display("FAIL both_do1 got=%h exp=8000000000000055", bus.do_data); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.full !== 2'b01) begin $display("FAIL both_after1 got=%b exp=01", bus.full); bad++; end
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL both_tx1 got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
        drive(1'b1, 1'b1, 64'h8000_0000_0000_0077, 1'b1);
        total++; if (bus.wr_ready !== 2'b10) begin $display("FAIL both_wr_ready2 got=%b exp=10", bus.wr_ready); bad++; end
        total++; if (bus.do_data !== 64'h44) begin $display("FAIL both_do0 got=%h exp=44", bus.do_data); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.full !== 2'b10) begin $display("FAIL both_concurrent got=%b exp=10", bus.full); bad++; end
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL both_tx2 got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
        drive(1'b0, 1'b0, 64'h0, 1'b1);
        total++; if (bus.do_data !== 64'h8000_0000_0000_0077) begin $display("FAIL both_do2 got=%h exp=8000000000000077", bus.do_data); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.full !== 2'b00) begin $display("FAIL both_empty got=%b exp=00", bus.full); bad++; end
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL both_tx3 got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
    endtask

    task automatic test_wrap();
        logic p;
        p = 1'b0;
        drive(p, 1'b1, 64'h1, 1'b0);
        tick();
        while (exp_tx != 16'hFFFF) begin
            p = ~p;
            drive(p, 1'b1, {p, 63'(exp_tx)}, 1'b1);
            tick();
            exp_tx++;
        end
        total++; if (bus.tx_count !== 16'hFFFF) begin $display("FAIL wrap_max got=%h exp=ffff", bus.tx_count); bad++; end
        p = ~p;
        drive(p, 1'b0, 64'h0, 1'b1);
        total++; if (bus.so !== 1'b1) begin $display("FAIL wrap_so got=%b exp=1", bus.so); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.tx_count !== 16'h0000) begin $display("FAIL wrap_zero got=%h exp=0000", bus.tx_count); bad++; end
        total++; if (bus.full !== 2'b00) begin $display("FAIL wrap_full got=%b exp=00", bus.full); bad++; end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 64'h99, 1'b0);
        tick();
        drive(1'b1, 1'b1, 64'h8000_0000_0000_00AA, 1'b1);
        tick();
        exp_tx++;
        drive(1'b0, 1'b0, 64'h0, 1'b0);
        total++; if (bus.so !== 1'b1) begin $display("FAIL arst_pre_so got=%b exp=1", bus.so); bad++; end
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.so !== 1'b0) begin $display("FAIL arst_so got=%b exp=0", bus.so); bad++; end
        total++; if (bus.do_data !== 64'h0) begin $display("FAIL arst_do got=%h exp=0", bus.do_data); bad++; end
        total++; if (bus.full !== 2'b00) begin $display("FAIL arst_full got=%b exp=00", bus.full); bad++; end
        total++; if (bus.wr_err !== 1'b0) begin $display("FAIL arst_wr_err got=%b exp=0", bus.wr_err); bad++; end
        total++; if (bus.tx_count !== 16'h0) begin $display("FAIL arst_tx got=%h exp=0", bus.tx_count); bad++; end
        total++; if (bus.wr_ready !== 2'b00) begin $display("FAIL arst_wr_ready got=%b exp=00", bus.wr_ready); bad++; end
        tick();
        reset  = 1'b0;
        exp_tx = 16'h0;
        drive(1'b0, 1'b1, 64'hBB, 1'b0);
        tick();
        total++; if (bus.full !== 2'b01) begin $display("FAIL arst_resume_full got=%b exp=01", bus.full); bad++; end
        drive(1'b1, 1'b0, 64'h0, 1'b1);
        total++; if (bus.do_data !== 64'hBB) begin $display("FAIL arst_resume_do got=%h exp=bb", bus.do_data); bad++; end
        tick();
        exp_tx++;
        total++; if (bus.tx_count !== exp_tx) begin $display("FAIL arst_resume_tx got=%h exp=%h", bus.tx_count, exp_tx); bad++; end
        total++; if (bus.wr_err !== 1'b0) begin $display("FAIL arst_resume_err got=%b exp=0", bus.wr_err); bad++; end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        exp_tx = 16'h0;
        reset  = 1'b1;
        bus.polarity = 1'b0;
        bus.wr_en    = 1'b0;
        bus.wr_data  = 64'h0;
        bus.ro       = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_wr_err();
        test_both_full();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
